// File: rtl/fp_multiplier.sv
// fp_multiplier
// Two-stage pipelined binary32 multiplier, round to nearest with ties to even.
// Subnormal operands are treated as zero and subnormal results are flushed
// to signed zero. No exception flags are produced.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset, clears every pipeline register
//   in_valid  : a/b hold an operand pair this cycle
//   a, b      : binary32 operands
//   result    : registered binary32 product
//   out_valid : result holds the product of the pair presented two edges ago
//
// Handshake: in_valid is a pure qualifier. There is no ready; the pipeline
// advances every cycle and out_valid is in_valid delayed by two edges.

module fp_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        out_valid
);

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } cls_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // ---------------------------------------------------------------------------
  // Stage 1: classify operands, multiply significands, add exponents
  // ---------------------------------------------------------------------------
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  cls_t        cls_next;
  logic [47:0] prod_next;
  logic signed [9:0] exp_next;

  assign ea = a[30:23];
  assign eb = b[30:23];
  assign fa = a[22:0];
  assign fb = b[22:0];

  // exp=0 covers subnormals too, which is what flushes them to zero
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

  always_comb begin
    cls_next = CLS_NORMAL;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      cls_next = CLS_NAN;
    else if (a_inf || b_inf)
      cls_next = CLS_INF;
    else if (a_zero || b_zero)
      cls_next = CLS_ZERO;
  end

  assign prod_next = 48'({1'b1, fa}) * 48'({1'b1, fb});
  assign exp_next  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

  logic              s1_valid;
  logic              s1_sign;
  cls_t              s1_cls;
  logic [47:0]       s1_prod;
  logic signed [9:0] s1_exp;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls   <= CLS_ZERO;
      s1_prod  <= 48'd0;
      s1_exp   <= 10'sd0;
    end else begin
      s1_valid <= in_valid;
      s1_sign  <= a[31] ^ b[31];
      s1_cls   <= cls_next;
      s1_prod  <= prod_next;
      s1_exp   <= exp_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: normalize, round, range check, pack
  // ---------------------------------------------------------------------------
  logic [22:0]       mant_pre, mant_fin;
  logic              guard, sticky, round_up;
  logic [23:0]       mant_sum;
  logic signed [9:0] exp_norm, exp_fin;
  logic [31:0]       result_next;

  always_comb begin
    // The product of two [1,2) significands lies in [1,4): at most one
    // position of normalization is ever needed.
    if (s1_prod[47]) begin
      mant_pre = s1_prod[46:24];
      guard    = s1_prod[23];
      sticky   = |s1_prod[22:0];
      exp_norm = s1_exp + 10'sd1;
    end else begin
      mant_pre = s1_prod[45:23];
      guard    = s1_prod[22];
      sticky   = |s1_prod[21:0];
      exp_norm = s1_exp;
    end

    // Ties go to the even mantissa: round up on a tie only if LSB is odd
    round_up = guard & (sticky | mant_pre[0]);
    mant_sum = {1'b0, mant_pre} + {23'd0, round_up};

    // All-ones mantissa rounding up becomes 1.0 at the next exponent
    if (mant_sum[23]) begin
      mant_fin = 23'd0;
      exp_fin  = exp_norm + 10'sd1;
    end else begin
      mant_fin = mant_sum[22:0];
      exp_fin  = exp_norm;
    end

    result_next = {s1_sign, 31'd0};
    case (s1_cls)
      CLS_NAN:  result_next = QNAN;
      CLS_INF:  result_next = {s1_sign, 8'hFF, 23'd0};
      CLS_ZERO: result_next = {s1_sign, 31'd0};
      default: begin
        if (exp_fin >= 10'sd255)
          result_next = {s1_sign, 8'hFF, 23'd0};
        else if (exp_fin <= 10'sd0)
          result_next = {s1_sign, 31'd0};
        else
          result_next = {s1_sign, exp_fin[7:0], mant_fin};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= 32'd0;
      out_valid <= 1'b0;
    end else begin
      result    <= result_next;
      out_valid <= s1_valid;
    end
  end

endmodule

// File: tb/tb_fp_multiplier.sv
// tb_fp_multiplier
// Directed bench for fp_multiplier. Expected products are pushed onto exp_q
// when a valid pair is driven and popped when out_valid is seen. out_valid is
// compared every cycle against in_valid delayed two edges (cleared by rst).

module tb_fp_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  fp_multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .result    (result),
    .out_valid (out_valid)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset-tracking block
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  logic armed    = 1'b0;
  logic exp_v1   = 1'b0;
  logic exp_v2   = 1'b0;
  logic rst_seen = 1'b0;

  always @(posedge clk) begin
    armed    <= 1'b1;
    rst_seen <= rst;
    exp_v1   <= rst ? 1'b0 : in_valid;
    exp_v2   <= rst ? 1'b0 : exp_v1;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: sample on the falling edge
  // ---------------------------------------------------------------------------
  logic [31:0] want;

  always @(negedge clk) begin
    if (armed) begin
      checks++;
      assert (out_valid === exp_v2) else begin
        errors++;
        $error("FAIL out_valid got %b expected %b", out_valid, exp_v2);
      end
      if (rst_seen) begin
        checks++;
        assert (result === 32'h0000_0000) else begin
          errors++;
          $error("FAIL reset_result got %08h expected 00000000", result);
        end
      end else if (exp_v2) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL underflow_q got result %08h with empty expected queue", result);
        end
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          checks++;
          assert (result === want) else begin
            errors++;
            $error("FAIL product got %08h expected %08h", result, want);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ev);
    @(negedge clk);
    #1;
    in_valid = v;
    a        = av;
    b        = bv;
    if (v) exp_q.push_back(ev);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h0);
  endtask

  localparam int NV = 25;

  logic [31:0] va [NV] = '{
    32'h4000_0000, 32'h3F00_0000, 32'h3FA0_0000, 32'hC000_0000, 32'h3F80_0000,
    32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0001,
    32'h7F00_0000, 32'h0080_0000, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0001,
    32'h3F80_0003, 32'h3F80_0001, 32'hFF80_0000, 32'h7F80_0000, 32'h0040_0000,
    32'h8000_0000, 32'hFFC0_0000, 32'h8080_0000, 32'hFF00_0000, 32'h0000_0000
  };
  logic [31:0] vb [NV] = '{
    32'h4040_0000, 32'h4080_0000, 32'h3FC0_0000, 32'h4040_0000, 32'hBF80_0000,
    32'h40A0_0000, 32'h40A0_0000, 32'h4000_0000, 32'h0000_0000, 32'h3F80_0000,
    32'h4000_0000, 32'h3F00_0000, 32'h3F80_0001, 32'h3FFF_FFFF, 32'h3FC0_0000,
    32'h3FC0_0000, 32'h3FFF_FFFE, 32'h4000_0000, 32'hFF80_0000, 32'h3F80_0000,
    32'hC000_0000, 32'h8000_0000, 32'h3F00_0000, 32'h4000_0000, 32'h7F80_0000
  };
  logic [31:0] vr [NV] = '{
    32'h40C0_0000, 32'h4000_0000, 32'h3FF0_0000, 32'hC0C0_0000, 32'hBF80_0000,
    32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000,
    32'h7F80_0000, 32'h0000_0000, 32'h3F80_0002, 32'h4000_0000, 32'h3FC0_0002,
    32'h3FC0_0004, 32'h4000_0000, 32'hFF80_0000, 32'hFF80_0000, 32'h0000_0000,
    32'h0000_0000, 32'h7FC0_0000, 32'h8000_0000, 32'hFF80_0000, 32'h7FC0_0000
  };

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 32'h4000_0000;
    b        = 32'h4040_0000;

    // reset held two edges with in_valid high: nothing may come out
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;

    // basic products back to back
    for (int i = 0; i < 3; i++) drive(1'b1, va[i], vb[i], vr[i]);

    // remaining vectors, with occasional idle gaps
    for (int i = 3; i < NV; i++) begin
      drive(1'b1, va[i], vb[i], vr[i]);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(3);

    // valid pattern 1,0,1,1
    drive(1'b1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    drive(1'b0, 32'h3F00_0000, 32'h4080_0000, 32'h0);
    drive(1'b1, 32'h3FA0_0000, 32'h3FC0_0000, 32'h3FF0_0000);
    drive(1'b1, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000);
    idle(3);

    // reset mid-stream: the older pair completes, the younger one is dropped
    drive(1'b1, 32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000);
    drive(1'b1, 32'h3F00_0000, 32'h4080_0000, 32'h4000_0000);
    @(negedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;

    // pipeline resumes after reset
    drive(1'b1, 32'h3F80_0001, 32'h3FFF_FFFE, 32'h4000_0000);
    idle(4);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
